// File: rtl/sobel_frame_ctrl.sv
// Frame controller between the UART receiver and the Sobel core: header parse, pixel forwarding, result count, error recovery.
// Optional idle-timeout abort is enabled by defining SOBEL_CTRL_TIMEOUT_EN.
module sobel_frame_ctrl #(
   parameter int MAX_WIDTH      = 640,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_err,
   output logic [7:0]  px_data,
   output logic        px_valid,
   input  logic        px_ready,
   output logic [15:0] cfg_width,
   output logic [15:0] cfg_height,
   output logic        cfg_load,
   output logic        core_clr,
   input  logic        res_valid,
   output logic        busy,
   output logic        frame_done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam logic [3:0] S_HDR0   = 4'd0;
   localparam logic [3:0] S_HDR1   = 4'd1;
   localparam logic [3:0] S_HDR2   = 4'd2;
   localparam logic [3:0] S_HDR3   = 4'd3;
   localparam logic [3:0] S_CFG    = 4'd4;
   localparam logic [3:0] S_STREAM = 4'd5;
   localparam logic [3:0] S_DRAIN  = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_ERR    = 4'd8;

   localparam logic [1:0] E_NONE = 2'd0;
   localparam logic [1:0] E_HDR  = 2'd1;
   localparam logic [1:0] E_RX   = 2'd2;
   localparam logic [1:0] E_TO   = 2'd3;

   localparam logic [15:0] MAX_W = 16'(MAX_WIDTH);

   logic [3:0]  state, state_nxt;
   logic [1:0]  ecode_nxt;
   logic [7:0]  w_lo, w_hi, h_lo;
   logic        hdr_ok;
   logic [31:0] pix_total, res_total;
   logic [31:0] pix_cnt, res_cnt, pix_cnt_nxt, res_cnt_nxt;
   logic [15:0] hdr_w, hdr_h;
   logic        hdr_valid, fwd, res_hit, timeout;

   // Height high byte is still on rx_data, so the header is judged as it arrives.
   assign hdr_w     = {w_hi, w_lo};
   assign hdr_h     = {rx_data, h_lo};
   assign hdr_valid = (hdr_w >= 16'd3) && (hdr_w <= MAX_W) && (hdr_h >= 16'd3);

   assign fwd     = (state == S_STREAM) && rx_valid && px_ready && !rx_err;
   assign res_hit = res_valid && ((state == S_STREAM) || (state == S_DRAIN));

   assign pix_cnt_nxt = (fwd && (pix_cnt != '1)) ? pix_cnt + 32'd1 : pix_cnt;
   assign res_cnt_nxt = (res_hit && (res_cnt != '1)) ? res_cnt + 32'd1 : res_cnt;

`ifdef SOBEL_CTRL_TIMEOUT_EN
   localparam logic [19:0] TO_LIM = 20'(TIMEOUT_CYCLES - 1);

   logic [19:0] idle_cnt;
   logic        idle_run;

   assign idle_run = (state == S_HDR1) || (state == S_HDR2) || (state == S_HDR3) ||
                     (state == S_STREAM) || (state == S_DRAIN);
   assign timeout  = idle_run && !rx_valid && !res_valid && (idle_cnt == TO_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         idle_cnt <= '0;
      else if (!idle_run || rx_valid || res_valid)
         idle_cnt <= '0;
      else if (idle_cnt != TO_LIM)
         idle_cnt <= idle_cnt + 20'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state;
      ecode_nxt = E_NONE;
      case (state)
         S_HDR0:   if (rx_valid) state_nxt = S_HDR1;
         S_HDR1:   if (rx_valid) state_nxt = S_HDR2;
         S_HDR2:   if (rx_valid) state_nxt = S_HDR3;
         S_HDR3:   if (rx_valid) state_nxt = S_CFG;
         S_CFG: begin
            if (hdr_ok) begin
               state_nxt = S_STREAM;
            end else begin
               state_nxt = S_ERR;
               ecode_nxt = E_HDR;
            end
         end
         S_STREAM: begin
            if (rx_valid && !px_ready) begin
               state_nxt = S_ERR;
               ecode_nxt = E_RX;
            end else if (pix_cnt_nxt == pix_total) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN:  if (res_cnt_nxt == res_total) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_HDR0;
         S_ERR:    state_nxt = S_HDR0;
         default:  state_nxt = S_HDR0;
      endcase
      if (timeout) begin
         state_nxt = S_ERR;
         ecode_nxt = E_TO;
      end
      // Receiver errors take priority over any byte presented in the same cycle.
      if (rx_err && (state != S_HDR0)) begin
         state_nxt = S_ERR;
         ecode_nxt = E_RX;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_HDR0;
         w_lo       <= '0;
         w_hi       <= '0;
         h_lo       <= '0;
         hdr_ok     <= 1'b0;
         pix_total  <= '0;
         res_total  <= '0;
         pix_cnt    <= '0;
         res_cnt    <= '0;
         px_data    <= '0;
         px_valid   <= 1'b0;
         cfg_width  <= '0;
         cfg_height <= '0;
         cfg_load   <= 1'b0;
         core_clr   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
         err_code   <= E_NONE;
      end else begin
         state      <= state_nxt;
         px_valid   <= fwd;
         cfg_load   <= 1'b0;
         core_clr   <= (state_nxt == S_ERR);
         frame_done <= (state_nxt == S_DONE);
         busy       <= (state_nxt != S_HDR0) && (state_nxt != S_DONE) && (state_nxt != S_ERR);

         if (fwd)
            px_data <= rx_data;

         if ((state == S_HDR0) && (state_nxt == S_HDR1)) w_lo <= rx_data;
         if ((state == S_HDR1) && (state_nxt == S_HDR2)) w_hi <= rx_data;
         if ((state == S_HDR2) && (state_nxt == S_HDR3)) h_lo <= rx_data;

         if ((state == S_HDR3) && (state_nxt == S_CFG)) begin
            hdr_ok <= hdr_valid;
            if (hdr_valid) begin
               cfg_width  <= hdr_w;
               cfg_height <= hdr_h;
               cfg_load   <= 1'b1;
            end
         end

         // A good header clears the sticky error together with the load strobe.
         if ((state == S_HDR3) && (state_nxt == S_CFG) && hdr_valid) begin
            err      <= 1'b0;
            err_code <= E_NONE;
         end else if (state_nxt == S_ERR) begin
            err      <= 1'b1;
            err_code <= ecode_nxt;
         end

         if (state == S_CFG) begin
            pix_total <= 32'(cfg_width) * 32'(cfg_height);
            res_total <= 32'(cfg_width - 16'd2) * 32'(cfg_height - 16'd2);
            pix_cnt   <= '0;
            res_cnt   <= '0;
         end else begin
            pix_cnt <= pix_cnt_nxt;
            res_cnt <= res_cnt_nxt;
         end
      end
   end

endmodule
